// File: rtl/exhaustive_stim_logger_if.sv
// Record stream from the stimulus logger to the downstream logger.
//
// Handshake: the master raises rec_valid with rec_pat/rec_bit stable and keeps
// all three unchanged until a rising edge where rec_valid && rec_ready are
// both high; that edge transfers exactly one record. rec_ready may be high at
// any time and has no effect while rec_valid is low.
interface exhaustive_stim_logger_if #(
  parameter int N_IN = 3
) ();

  logic            rec_valid;
  logic            rec_ready;
  logic [N_IN-1:0] rec_pat;
  logic            rec_bit;

  modport master (
    output rec_valid,
    output rec_pat,
    output rec_bit,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_pat,
    input  rec_bit,
    output rec_ready
  );

endinterface

// File: rtl/exhaustive_stim_logger.sv
// Exhaustive stimulus/response stage for a small N_IN-input, 1-output DUT.
// Walks patterns 0 .. 2^N_IN-1 in ascending order, holds each for SETTLE
// cycles, samples the DUT response, streams a (pattern, response) record and
// builds a full response vector plus a ones count for golden comparison.
module exhaustive_stim_logger #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                     CK,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic [0:N_IN-1]          pat_out,
  input  logic                     dut_out,
  exhaustive_stim_logger_if.master rec,
  output logic [(1<<N_IN)-1:0]     resp_vec,
  output logic [N_IN:0]            ones_cnt,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Last settle-counter value before sampling (SETTLE is 1..255).
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  // Terminal pattern held in the widened counter, so no wrap is ever needed.
  localparam logic [N_IN:0] PAT_LAST = {1'b0, {N_IN{1'b1}}};

  logic [2:0]      state;
  logic [2:0]      state_next;
  logic [N_IN:0]   pat_cnt;
  logic [7:0]      settle_cnt;
  logic [N_IN-1:0] rec_pat_q;
  logic            rec_bit_q;
  logic [N_IN-1:0] pat_idx;
  logic            handshake;

  assign pat_idx   = pat_cnt[N_IN-1:0];
  assign handshake = (state == S_EMIT) && rec.rec_ready;

  // Next-state decode; abort from any active state returns straight to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        state_next = S_EMIT;
      end
      S_EMIT: begin
        if (handshake) begin
          state_next = (pat_cnt == PAT_LAST) ? S_DONE : S_SETTLE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (abort && (state != S_IDLE)) begin
      state_next = S_IDLE;
    end
  end

  // State register plus pattern/settle counters and the record/result datapath.
  always_ff @(posedge CK) begin
    if (reset) begin
      state      <= S_IDLE;
      pat_cnt    <= '0;
      settle_cnt <= '0;
      rec_pat_q  <= '0;
      rec_bit_q  <= 1'b0;
      resp_vec   <= '0;
      ones_cnt   <= '0;
    end else begin
      state <= state_next;

      // New sweep: clear results and begin at pattern 0.
      if ((state == S_IDLE) && (state_next == S_SETTLE)) begin
        pat_cnt    <= '0;
        settle_cnt <= '0;
        resp_vec   <= '0;
        ones_cnt   <= '0;
      end

      // Count settle cycles while the pattern is held.
      if ((state == S_SETTLE) && (state_next == S_SETTLE)) begin
        settle_cnt <= settle_cnt + 8'd1;
      end

      // Capture the response at the end of the sample cycle.
      if ((state == S_SAMPLE) && (state_next == S_EMIT)) begin
        rec_pat_q         <= pat_idx;
        rec_bit_q         <= dut_out;
        resp_vec[pat_idx] <= dut_out;
        ones_cnt          <= ones_cnt + {{N_IN{1'b0}}, dut_out};
      end

      // Record accepted and more patterns remain: advance the pattern.
      if ((state == S_EMIT) && (state_next == S_SETTLE)) begin
        pat_cnt    <= pat_cnt + 1'b1;
        settle_cnt <= '0;
      end

      // Any return to IDLE (completion or abort) parks the pattern at 0.
      if ((state != S_IDLE) && (state_next == S_IDLE)) begin
        pat_cnt    <= '0;
        settle_cnt <= '0;
      end
    end
  end

  // Pattern is presented with bit 0 as MSB; vector assignment is positional.
  assign pat_out = pat_idx;

  assign rec.rec_valid = (state == S_EMIT);
  assign rec.rec_pat   = rec_pat_q;
  assign rec.rec_bit   = rec_bit_q;

  assign busy      = (state == S_SETTLE) || (state == S_SAMPLE) || (state == S_EMIT);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_exhaustive_stim_logger.sv
// Directed bench for exhaustive_stim_logger: table of full sweeps with
// hand-computed results, plus hand sequences for abort and reset corners.
module tb_exhaustive_stim_logger;

  localparam int N_IN   = 3;
  localparam int SETTLE = 1;
  localparam int W      = N_IN + 1;

  // ---------------- clock / reset ----------------
  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic              reset;
  logic              start;
  logic              abort;
  logic [0:N_IN-1]   pat_out;
  logic              dut_out;
  logic [(1<<N_IN)-1:0] resp_vec;
  logic [N_IN:0]     ones_cnt;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;
  logic              dut_mode;   // 0: AND of all bits, 1: XOR parity

  exhaustive_stim_logger_if #(.N_IN(N_IN)) rec_if ();

  exhaustive_stim_logger #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .CK        (CK),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .pat_out   (pat_out),
    .dut_out   (dut_out),
    .rec       (rec_if),
    .resp_vec  (resp_vec),
    .ones_cnt  (ones_cnt),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Small DUT under test: combinational function of the driven pattern.
  always_comb dut_out = dut_mode ? (^pat_out) : (&pat_out);

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic model_bit(input logic mode, input int p);
    logic [2:0] v;
    v = p[2:0];
    return mode ? (v[0] ^ v[1] ^ v[2]) : (v[0] & v[1] & v[2]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CK);
    #1;
    cyc++;
  endtask

  typedef struct {
    logic       mode;
    int         stall_pat;
    int         stall_n;
    logic [7:0] exp_resp;
    logic [3:0] exp_ones;
    int         exp_done;
    int         pulse0;
    int         pulse1;
    int         pulse2;
  } sweep_t;

  sweep_t tbl[6];

  task automatic run_sweep(input sweep_t s);
    int   done_cyc;
    int   stall_left;
    logic stall_active;
    logic [N_IN-1:0] held_pat;
    logic held_bit;
    logic [W-1:0] got;
    logic [W-1:0] exp;
    dut_mode = s.mode;
    exp_q.delete();
    for (int p = 0; p < (1 << N_IN); p++) exp_q.push_back({p[2:0], model_bit(s.mode, p)});
    done_cyc = -1;
    stall_left = s.stall_n;
    stall_active = 1'b0;
    held_pat = '0;
    held_bit = 1'b0;
    rec_if.rec_ready = 1'b1;
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_resp_clear", 32'(resp_vec), 32'h0);
    check("start_ones_clear", 32'(ones_cnt), 32'h0);
    check("start_pat0", 32'(pat_out), 32'h0);
    while (cyc < 200) begin
      start = (cyc == s.pulse0) || (cyc == s.pulse1) || (cyc == s.pulse2);
      if (done) begin
        done_cyc = cyc;
        check("done_busy_low", 32'(busy), 32'd0);
        check("done_valid_low", 32'(rec_if.rec_valid), 32'd0);
        break;
      end
      if (stall_active) begin
        check("stall_valid", 32'(rec_if.rec_valid), 32'd1);
        check("stall_rec_pat", 32'(rec_if.rec_pat), 32'(held_pat));
        check("stall_rec_bit", 32'(rec_if.rec_bit), 32'(held_bit));
        check("stall_pat_out", 32'(pat_out), 32'(held_pat));
      end
      if (rec_if.rec_valid && (int'(rec_if.rec_pat) == s.stall_pat) && (stall_left > 0)) begin
        if (!stall_active) begin
          held_pat = rec_if.rec_pat;
          held_bit = rec_if.rec_bit;
          stall_active = 1'b1;
        end
        rec_if.rec_ready = 1'b0;
        stall_left--;
      end else begin
        rec_if.rec_ready = 1'b1;
        stall_active = 1'b0;
      end
      if (rec_if.rec_valid && rec_if.rec_ready) begin
        got = {rec_if.rec_pat, rec_if.rec_bit};
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rec_unexpected: got record 0x%0h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          check("record", 32'(got), 32'(exp));
          check("emit_pat_out", 32'(pat_out), 32'(rec_if.rec_pat));
        end
      end
      step();
    end
    check("done_cycle", 32'(done_cyc), 32'(s.exp_done));
    check("resp_vec", 32'(resp_vec), 32'(s.exp_resp));
    check("ones_cnt", 32'(ones_cnt), 32'(s.exp_ones));
    check("records_left", 32'(exp_q.size()), 32'd0);
    step();
    start = 1'b0;
    check("idle_done_low", 32'(done), 32'd0);
    check("idle_busy_low", 32'(busy), 32'd0);
    check("idle_pat0", 32'(pat_out), 32'h0);
    check("idle_resp_held", 32'(resp_vec), 32'(s.exp_resp));
    step();
    check("no_restart", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pat_out"}, 32'(pat_out), 32'h0);
    check({tag, "_rec_valid"}, 32'(rec_if.rec_valid), 32'd0);
    check({tag, "_rec_pat"}, 32'(rec_if.rec_pat), 32'h0);
    check({tag, "_rec_bit"}, 32'(rec_if.rec_bit), 32'd0);
    check({tag, "_resp_vec"}, 32'(resp_vec), 32'h0);
    check({tag, "_ones_cnt"}, 32'(ones_cnt), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int   budget;
    logic seen_done;

    //            mode  stall_pat stall_n resp   ones done  pulses
    tbl[0] = '{1'b0, -1, 0, 8'h80, 4'd1, 25, -1, -1, -1};  // AND
    tbl[1] = '{1'b1, -1, 0, 8'h96, 4'd4, 25, -1, -1, -1};  // XOR, clears prior 0x80
    tbl[2] = '{1'b1, -1, 0, 8'h96, 4'd4, 25, -1, -1, -1};  // XOR repeat, identical
    tbl[3] = '{1'b0,  3, 4, 8'h80, 4'd1, 29, -1, -1, -1};  // backpressure on 011
    tbl[4] = '{1'b1, -1, 0, 8'h96, 4'd4, 25,  5, 24, 25};  // stray starts
    tbl[5] = '{1'b1,  3, 4, 8'h96, 4'd4, 29, -1, -1, -1};  // backpressure, parity

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    dut_mode = 1'b0;
    rec_if.rec_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_reset_values("reset");

    for (int i = 0; i < 6; i++) run_sweep(tbl[i]);

    // Abort during SETTLE of pattern 101 keeps partial parity results.
    dut_mode = 1'b1;
    rec_if.rec_ready = 1'b1;
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    budget = 0;
    while ((int'(pat_out) != 5) && (budget < 100)) begin
      step();
      budget++;
    end
    check("abort_reach_101", 32'(pat_out), 32'h5);
    check("abort_at_cycle16", 32'(cyc), 32'd16);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pat_out", 32'(pat_out), 32'h0);
    check("abort_valid", 32'(rec_if.rec_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_resp_partial", 32'(resp_vec), 32'h16);
    check("abort_ones_partial", 32'(ones_cnt), 32'd3);
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (done || busy) seen_done = 1'b1;
      step();
    end
    check("abort_quiet", 32'(seen_done), 32'd0);

    // Abort alone in IDLE does nothing; abort with start blocks the start.
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_abort_resp", 32'(resp_vec), 32'h16);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("abort_beats_start", 32'(busy), 32'd0);
    step();
    check("abort_beats_start_2", 32'(busy), 32'd0);
    check("abort_beats_start_resp", 32'(resp_vec), 32'h16);

    // Reset together with start while the 010 record is being emitted.
    dut_mode = 1'b1;
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    budget = 0;
    while (!(rec_if.rec_valid && (int'(rec_if.rec_pat) == 2)) && (budget < 100)) begin
      step();
      budget++;
    end
    check("reset_reach_010", 32'(rec_if.rec_pat), 32'h2);
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    check_reset_values("midreset");
    step();
    check("midreset_no_start", 32'(busy), 32'd0);
    run_sweep(tbl[1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net in case a loop above never terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/exhaustive_stim_logger.md
Name: exhaustive_stim_logger

Overview:
- Hardware stimulus/response stage that sits directly upstream of, and wraps, a small combinational or sequential DUT under trojan-detection test.
- Walks every input pattern of an N_IN-bit DUT in ascending binary order and waits a programmable settle time per pattern.
- Samples the DUT's single-bit output and streams each (pattern, response) record to a downstream logger over a valid/ready handshake.
- Also accumulates a full response vector and a ones count for quick golden-vs-suspect comparison.

Parameters:
- N_IN, 3, DUT input width; patterns 0 .. 2^N_IN-1.
- SETTLE, 1, cycles a pattern is held before sampling; legal range 1..255.

Ports:
- CK  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  synchronous sweep cancel.
- pat_out  output  N_IN  pattern driven to DUT; declared [0:N_IN-1], bit 0 is MSB (pattern 3'b001 sets bit 2).
- dut_out  input  1  DUT response bit.
- rec_valid  output  1  record available.
- rec_ready  input  1  downstream accepts record.
- rec_pat  output  N_IN  pattern of current record.
- rec_bit  output  1  sampled response of current record.
- resp_vec  output  2^N_IN  bit k = response to pattern k.
- ones_cnt  output  N_IN+1  number of patterns with response 1.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse at sweep completion.

Behaviour:
- Reset, synchronous to CK: state IDLE; pat_out=0; rec_valid=0; rec_pat=0; rec_bit=0; resp_vec=0; ones_cnt=0; busy=0; done=0; settle counter=0. Reset overrides start and abort in the same cycle.
- States: IDLE, SETTLE, SAMPLE, EMIT, DONE.
- IDLE, start=1 at edge t:
  - t+1: SETTLE, pat_out=0, busy=1, resp_vec=0, ones_cnt=0.
- SETTLE:
  - Holds pat_out for exactly SETTLE cycles, then goes to SAMPLE.
- SAMPLE (1 cycle):
  - At the edge ending this state: rec_bit<=dut_out, rec_pat<=pat_out, resp_vec[pat_out]<=dut_out, ones_cnt+=dut_out.
  - Next state EMIT.
- EMIT:
  - rec_valid=1; rec_pat and rec_bit held stable while rec_ready=0.
  - Handshake at the edge where rec_valid & rec_ready.
  - After the handshake: if pat_out != 2^N_IN-1, then pat_out+=1, rec_valid=0, go to SETTLE.
  - After the final handshake: pat_out unchanged, go to DONE.
  - rec_ready may be high before rec_valid; it has no effect outside EMIT.
- DONE (1 cycle): done=1, busy=0, rec_valid=0; then IDLE.
  - resp_vec and ones_cnt are held until the next start.
  - pat_out returns to 0 on entering IDLE.
- Throughput: with rec_ready tied high, each pattern takes SETTLE+2 cycles. done is high at cycle t+2^N_IN*(SETTLE+2)+1.
- start while busy or in DONE: ignored, with no restart and no counter disturbance.
- abort=1 in any non-IDLE state: next cycle IDLE, busy=0, rec_valid=0, pat_out=0, done not pulsed; resp_vec and ones_cnt keep their partial values.
  - abort in IDLE: no effect.
  - abort and start in the same IDLE cycle: abort wins, and no sweep starts.
- Pattern counter is N_IN+1 bits internally so the terminal test never relies on wrap-around. pat_out never wraps past 2^N_IN-1.
- ones_cnt saturation is impossible by width: maximum 2^N_IN fits in N_IN+1 bits.

Test Plan:
- N_IN=3, SETTLE=1, DUT=AND of all bits, rec_ready=1, start at cycle 0:
  - 8 records with rec_pat 000..111 in order, rec_bit 0 for 000..110 and 1 for 111.
  - resp_vec=8'b1000_0000, ones_cnt=4'd1.
  - done pulses exactly at cycle 25, and busy drops the same cycle.
- Same setup with DUT=XOR (parity):
  - resp_vec=8'b1001_0110, ones_cnt=4'd4.
  - A second start after done clears resp_vec to 0 before refilling it, and yields an identical result.
- Backpressure: rec_ready=0 for 4 cycles while the rec_pat=011 record is valid:
  - rec_valid stays 1, and rec_pat=011, rec_bit and pat_out=011 stay stable.
  - The sweep completes with done delayed by exactly 4 cycles (cycle 29).
- abort asserted during SETTLE of pattern 101:
  - Next cycle IDLE, busy=0, pat_out=000, rec_valid=0.
  - No done pulse; resp_vec bits 0..4 are retained.
- reset asserted mid-EMIT of pattern 010 together with start:
  - Next cycle all outputs hold their reset values and the sweep does not start.
  - A subsequent start runs a full clean sweep.
- start pulsed again at cycles 5 and 24 during a sweep: no effect on record order, resp_vec, or done timing (cycle 25).
